datapath_sequencer: RTL



---
 rtl/datapath_sequencer_pkg.sv | 16 +
 rtl/datapath_sequencer_if.sv | 43 ++++
 rtl/datapath_sequencer_buffer.sv | 26 ++
 rtl/datapath_sequencer.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/datapath_sequencer_pkg.sv
// Shared types and constants for the datapath sequencer: FSM states, the NOP
// encoding and the two InitSel selector values.
package datapath_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } seq_state_t;

  localparam logic [15:0] NOP_INSTR     = 16'h0000;
  localparam logic        INITSEL_DATA  = 1'b0;
  localparam logic        INITSEL_INSTR = 1'b1;

endpackage

// File: rtl/datapath_sequencer_if.sv
// Host/datapath-facing bundle of the datapath sequencer. The step input exists
// only when DATAPATH_SEQUENCER_STEP_EN is defined.
interface datapath_sequencer_if #(
  parameter int DW    = 16,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

`ifdef DATAPATH_SEQUENCER_STEP_EN
  logic          step;
`endif
  logic          start;
  logic          init_valid;
  logic [DW-1:0] init_data;
  logic          init_ready;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [DW-1:0] prog_data;
  logic [AW:0]   prog_len;
  logic [DW-1:0] Instruction;
  logic [DW-1:0] DataInit;
  logic          InitSel;
  logic          busy;
  logic          done;
  logic [AW-1:0] pc;

  modport master (
`ifdef DATAPATH_SEQUENCER_STEP_EN
    output step,
`endif
    output start, init_valid, init_data, prog_we, prog_addr, prog_data, prog_len,
    input  init_ready, Instruction, DataInit, InitSel, busy, done, pc
  );

  modport slave (
`ifdef DATAPATH_SEQUENCER_STEP_EN
    input  step,
`endif
    input  start, init_valid, init_data, prog_we, prog_addr, prog_data, prog_len,
    output init_ready, Instruction, DataInit, InitSel, busy, done, pc
  );

endinterface

// File: rtl/datapath_sequencer_buffer.sv
// Instruction buffer: DEPTH x DW register array, synchronous write and
// combinational read. Contents are deliberately not reset.
module seq_instr_buffer #(
  parameter int DW    = 16,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/datapath_sequencer.sv
// Datapath sequencer: streams INIT_WORDS init words, then issues prog_len
// buffered instructions. Optional macro DATAPATH_SEQUENCER_STEP_EN gates issue.
module datapath_sequencer
  import datapath_seq_pkg::*;
#(
  parameter int DW         = 16,
  parameter int DEPTH      = 16,
  parameter int INIT_WORDS = 16
) (
  input logic                 clk,
  input logic                 reset,
  datapath_sequencer_if.slave bus
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [15:0] LAST_INIT = 16'(INIT_WORDS - 1);

  seq_state_t    state_q, state_d;
  logic [15:0]   init_cnt_q, init_cnt_d;
  logic [AW:0]   len_q, len_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] instr_q, instr_d;
  logic [DW-1:0] data_init_q, data_init_d;
  logic          init_sel_q, init_sel_d;
  logic          init_ready_q, init_ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [DW-1:0] buf_rdata;
  logic          handshake;
  logic          issue;
  logic          last_instr;

  seq_instr_buffer #(
    .DW   (DW),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_buffer (
    .clk  (clk),
    .we   (bus.prog_we && (state_q == IDLE)),
    .waddr(bus.prog_addr),
    .wdata(bus.prog_data),
    .raddr(pc_q),
    .rdata(buf_rdata)
  );

`ifdef DATAPATH_SEQUENCER_STEP_EN
  assign issue = bus.step;
`else
  assign issue = 1'b1;
`endif

  assign handshake  = bus.init_valid && init_ready_q;
  assign last_instr = ({1'b0, pc_q} == (len_q - (AW+1)'(1)));

  // done is raised on the edge that enters DONE, so it is visible for the
  // single cycle spent in DONE; busy and done both drop on leaving it.
  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    len_d        = len_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    data_init_d  = data_init_q;
    init_sel_d   = init_sel_q;
    init_ready_d = init_ready_q;
    busy_d       = busy_q;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          len_d        = bus.prog_len;
          init_cnt_d   = 16'd0;
          init_ready_d = 1'b1;
          busy_d       = 1'b1;
          state_d      = INIT;
        end
      end

      INIT: begin
        if (handshake) begin
          data_init_d = bus.init_data;
          init_sel_d  = INITSEL_DATA;
          init_cnt_d  = init_cnt_q + 16'd1;
          if (init_cnt_q == LAST_INIT) begin
            init_ready_d = 1'b0;
            pc_d         = '0;
            if (len_q == '0) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = RUN;
            end
          end
        end else begin
          init_sel_d = INITSEL_INSTR;
        end
      end

      RUN: begin
        init_sel_d = INITSEL_INSTR;
        if (issue) begin
          instr_d = buf_rdata;
          pc_d    = pc_q + AW'(1);
          if (last_instr) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end else begin
          instr_d = DW'(NOP_INSTR);
        end
      end

      DONE: begin
        instr_d = DW'(NOP_INSTR);
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      init_cnt_q   <= 16'd0;
      len_q        <= '0;
      pc_q         <= '0;
      instr_q      <= DW'(NOP_INSTR);
      data_init_q  <= '0;
      init_sel_q   <= INITSEL_INSTR;
      init_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      len_q        <= len_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      data_init_q  <= data_init_d;
      init_sel_q   <= init_sel_d;
      init_ready_q <= init_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.Instruction = instr_q;
  assign bus.DataInit    = data_init_q;
  assign bus.InitSel     = init_sel_q;
  assign bus.init_ready  = init_ready_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.pc          = pc_q;

endmodule
